// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the fetch port and the
//            load/store port, with data priority and optional fetch fairness
//            enabled by the MEM_ARB_FAIR_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] c_OP_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   w_pick_data;

`ifdef MEM_ARB_FAIR_EN
    localparam int                    c_STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_STREAK);

    logic [c_STREAK_W-1:0] r_streak;

    // A pending fetch overrides data once data has won MAX_STREAK times in a row.
    assign w_pick_data = d_req && !(if_req && (r_streak == c_STREAK_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pick_data) begin
                r_streak <= if_req ? r_streak + 1'b1 : '0;
            end else if (if_req) begin
                r_streak <= '0;
            end
        end
    end
`else
    localparam int c_unused_max_streak = MAX_STREAK;

    assign w_pick_data = d_req;
`endif

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_op    <= 3'b000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_data) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_op    <= d_op;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        r_state   <= S_GNT_D;
                    end else if (if_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_op    <= c_OP_WORD;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        r_state   <= S_GNT_I;
                    end
                end
                S_GNT_I: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        mem_req  <= 1'b0;
                        r_state  <= S_RESP;
                    end
                end
                S_GNT_D: begin
                    if (mem_ready) begin
                        d_rdata <= mem_rdata;
                        d_ready <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Requesters swap their request this cycle, so it is not sampled.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter: directed corner cases
//            followed by randomized fetch/load/store traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_STREAK = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit c_FAIR = 1'b1;
`else
    localparam bit c_FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [2:0]        d_op = 3'b000;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_op      (d_op),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model and memory image ----------------
    typedef struct {
        bit          chk;
        logic [31:0] val;
    } d_exp_t;

    logic [31:0] if_q[$];
    d_exp_t      d_q[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] model_arr[logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_arr.exists(a) ? model_arr[a] : init_val(a);
    endfunction

    // ---------------- request snapshot (what the next edge samples) ----------------
    logic        p_if, p_d, p_d_we;
    logic [2:0]  p_d_op;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;

    always @(negedge clk) begin
        p_if      = if_req;
        p_d       = d_req;
        p_d_we    = d_we;
        p_d_op    = d_op;
        p_if_addr = if_addr;
        p_d_addr  = d_addr;
        p_d_wdata = d_wdata;
    end

    // ---------------- memory responder and grant checker ----------------
    int          wait_force = -1;
    bit          stray = 1'b0;
    bit          busy = 1'b0;
    int          wait_left, req_cycles, last_req_cycles, g_cyc;
    int          streak_m = 0;
    int          n_grants = 0, n_i_grants = 0, first_fetch = 0, fetch_in_20 = -1;
    logic        e_we;
    logic [2:0]  e_op;
    logic [31:0] e_addr, e_wdata;

    task automatic grant_check();
        bit exp_data;
        if (!p_if && !p_d) check(1'b0, "spurious_grant", 1, 0);
        exp_data = p_d && !(c_FAIR && p_if && (streak_m == MAX_STREAK));
        if (exp_data) begin
            e_we = p_d_we; e_op = p_d_op; e_addr = p_d_addr; e_wdata = p_d_wdata;
            streak_m = p_if ? streak_m + 1 : 0;
        end else begin
            e_we = 1'b0; e_op = 3'b010; e_addr = p_if_addr; e_wdata = 32'h0;
            streak_m = 0;
            n_i_grants++;
            if (first_fetch == 0) first_fetch = n_grants + 1;
        end
        n_grants++;
        if (n_grants == 20) fetch_in_20 = n_i_grants;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (reset) begin
                busy     = 1'b0;
                streak_m = 0;
            end else if (stray) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end else begin
                if (mem_req && !busy) begin
                    busy       = 1'b1;
                    req_cycles = 0;
                    g_cyc      = cyc;
                    wait_left  = (wait_force >= 0) ? wait_force : int'($urandom_range(0, 3));
                    grant_check();
                end
                if (busy) begin
                    req_cycles++;
                    check(mem_req == 1'b1, "mem_req_held", mem_req, 1);
                    check(mem_addr == e_addr, "mem_addr", mem_addr, e_addr);
                    check(mem_we == e_we, "mem_we", mem_we, e_we);
                    check(mem_op == e_op, "mem_op", mem_op, e_op);
                    check(mem_wdata == e_wdata, "mem_wdata", mem_wdata, e_wdata);
                    if (wait_left == 0) begin
                        mem_ready = 1'b1;
                        if (mem_we) begin
                            mem_rdata        = $urandom;
                            mem_arr[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = mem_read(mem_addr);
                        end
                        busy            = 1'b0;
                        last_req_cycles = req_cycles;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [31:0] if_last = 32'h0, d_last = 32'h0;
    bit          d_hold = 1'b1;
    int          if_rdy_cyc = 0, d_rdy_cyc = 0, n_pulses = 0;

    initial begin
        forever begin
            @(negedge clk);
            check(stall_if == (if_req & ~if_ready), "stall_if", stall_if, if_req & ~if_ready);
            check(stall_mem == (d_req & ~d_ready), "stall_mem", stall_mem, d_req & ~d_ready);
            if (if_ready) begin
                n_pulses++;
                if_rdy_cyc = cyc;
                if (if_q.size() == 0) begin
                    check(1'b0, "if_unexpected_ready", 1, 0);
                end else begin
                    if_last = if_q.pop_front();
                    check(if_rdata == if_last, "if_rdata", if_rdata, if_last);
                end
            end else begin
                check(if_rdata == if_last, "if_rdata_hold", if_rdata, if_last);
            end
            if (d_ready) begin
                d_exp_t e;
                n_pulses++;
                d_rdy_cyc = cyc;
                if (d_q.size() == 0) begin
                    check(1'b0, "d_unexpected_ready", 1, 0);
                end else begin
                    e = d_q.pop_front();
                    if (e.chk) begin
                        check(d_rdata == e.val, "d_rdata", d_rdata, e.val);
                        d_last = e.val;
                        d_hold = 1'b1;
                    end else begin
                        d_hold = 1'b0;
                    end
                end
            end else if (d_hold) begin
                check(d_rdata == d_last, "d_rdata_hold", d_rdata, d_last);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit issue_en = 1'b0;
    int gap_max = 0, if_gap = 0, d_gap = 0;

    task automatic issue_fetch(input logic [31:0] a, input logic [31:0] exp);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(exp);
    endtask

    task automatic issue_data(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        d_exp_t e;
        d_we    = we;
        d_op    = op;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        e.chk   = !we;
        e.val   = we ? 32'h0 : model_read(a);
        if (we) model_arr[a] = wd;
        d_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (if_req && if_ready) begin if_req = 1'b0; if_gap = $urandom_range(0, gap_max); end
        if (d_req && d_ready) begin d_req = 1'b0; d_gap = $urandom_range(0, gap_max); end
        if (issue_en && !if_req) begin
            if (if_gap == 0) begin
                logic [31:0] a;
                a = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                issue_fetch(a, init_val(a));
            end else begin
                if_gap--;
            end
        end
        if (issue_en && !d_req) begin
            if (d_gap == 0) issue_data(1'($urandom), 3'($urandom), 32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
            else d_gap--;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((if_req || d_req || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            check(1'b0, name, n, budget);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        int pulses0;
        repeat (3) @(posedge clk);
        #1;
        check(mem_req == 1'b0, "rst_mem_req", mem_req, 0);
        check(mem_addr == 32'h0, "rst_mem_addr", mem_addr, 0);
        check({mem_we, mem_op} == 4'h0, "rst_mem_we_op", {mem_we, mem_op}, 0);
        check(mem_wdata == 32'h0, "rst_mem_wdata", mem_wdata, 0);
        check({if_ready, d_ready} == 2'b00, "rst_ready", {if_ready, d_ready}, 0);
        check({if_rdata, d_rdata} == 64'h0, "rst_rdata", {if_rdata, d_rdata}, 0);
        reset = 1'b0;

        // Single zero-wait fetch.
        wait_force = 0;
        mem_arr[32'h40] = 32'h0051_0093;
        tick();
        issue_fetch(32'h40, 32'h0051_0093);
        drain(50, "timeout_single_fetch");
        check(if_rdy_cyc - g_cyc == 1, "fetch_latency", if_rdy_cyc - g_cyc, 1);

        // Store with three wait cycles, then read it back.
        wait_force = 3;
        tick();
        issue_data(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        drain(50, "timeout_store");
        check(last_req_cycles == 4, "store_req_cycles", last_req_cycles, 4);
        check(d_rdy_cyc - g_cyc == 4, "store_latency", d_rdy_cyc - g_cyc, 4);
        wait_force = 0;
        tick();
        issue_data(1'b0, 3'b010, 32'h100, 32'h0);
        drain(50, "timeout_load_back");

        // Simultaneous requests: data first, fetch three cycles later.
        tick();
        issue_fetch(32'h1040, init_val(32'h1040));
        issue_data(1'b0, 3'b100, 32'h104, 32'h0);
        drain(50, "timeout_simultaneous");
        check(if_rdy_cyc - d_rdy_cyc == 3, "loser_spacing", if_rdy_cyc - d_rdy_cyc, 3);

        // Stray mem_ready in IDLE.
        pulses0 = n_pulses;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) tick();
        check(n_pulses == pulses0, "stray_ready", n_pulses - pulses0, 0);

        // Reset while a load waits in GNT_D.
        wait_force = 20;
        tick();
        issue_data(1'b0, 3'b001, 32'h108, 32'h0);
        tick();
        tick();
        check(mem_req == 1'b1, "mem_req_before_reset", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check(mem_req == 1'b0, "reset_drops_mem_req", mem_req, 0);
        d_req = 1'b0;
        if_q.delete();
        d_q.delete();
        if_last = 32'h0;
        d_last  = 32'h0;
        d_hold  = 1'b1;
        pulses0 = n_pulses;
        tick();
        tick();
        reset = 1'b0;
        wait_force = 0;
        repeat (3) tick();
        check(mem_req == 1'b0, "idle_after_reset", mem_req, 0);
        check(n_pulses == pulses0, "no_ready_after_abort", n_pulses - pulses0, 0);
        issue_fetch(32'h1080, init_val(32'h1080));
        drain(50, "timeout_after_reset");

        // Continuous data traffic with a fetch pending.
        n_grants = 0; n_i_grants = 0; first_fetch = 0; fetch_in_20 = -1;
        gap_max = 0; if_gap = 0; d_gap = 0;
        issue_en = 1'b1;
        for (int n = 0; n < 300 && n_grants < 20; n++) tick();
        issue_en = 1'b0;
        drain(200, "timeout_streak_drain");
`ifdef MEM_ARB_FAIR_EN
        check(first_fetch == 5, "fair_fetch_grant_index", first_fetch, 5);
`else
        check(fetch_in_20 == 0, "strict_no_fetch_in_20", fetch_in_20, 0);
`endif

        // Randomized mixed traffic.
        wait_force = -1;
        gap_max = 3;
        issue_en = 1'b1;
        repeat (2000) tick();
        issue_en = 1'b0;
        drain(300, "timeout_random_drain");
        check(if_q.size() == 0, "if_q_empty", if_q.size(), 0);
        check(d_q.size() == 0, "d_q_empty", d_q.size(), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
